// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch port and a MEM-stage data port. Data accesses have priority; each
// grant runs IDLE/RESP -> ACCESS (WAIT_CYCLES cycles) -> RESP.
// Optional build macro: ARB_PERF_CNT_EN enables the fetch-conflict counter
// on conflict_cnt; without it conflict_cnt is tied to zero.
// WAIT_CYCLES must lie in 1..7 (the wait counter is 3 bits wide).
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline stalls and statistics
  output logic              stall_if,
  output logic              stall_mem,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t            state_q,    state_d;
  logic [2:0]        wait_q,     wait_d;
  logic              owner_data_q, owner_data_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              we_q,       we_d;
  logic              mem_en_q,   mem_en_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q,  d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

  logic d_pend;
  logic if_pend;
  logic grant;
  logic grant_data;

  // Arbitration: a requester being acknowledged this cycle is not pending,
  // so a held request is not granted twice; data beats fetch.
  always_comb begin
    d_pend     = (d_read | d_write) & ~d_ready_q;
    if_pend    = if_req & ~if_ready_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    if (state_q == IDLE || state_q == RESP) begin
      grant      = d_pend | if_pend;
      grant_data = d_pend;
    end
  end

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (grant) begin
          state_d      = ACCESS;
          wait_d       = WAIT_LOAD;
          owner_data_d = grant_data;
          mem_en_d     = 1'b1;
          if (grant_data) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // simultaneous read and write resolves to a write
            we_d    = d_write;
          end else begin
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        wait_d = wait_q - 3'd1;
        if (wait_q <= 3'd1) begin
          wait_d  = 3'd0;
          state_d = RESP;
          if (owner_data_q) begin
            d_ready_d = 1'b1;
            // a store leaves the load-data register untouched
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_q       <= 3'd0;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q, conflict_d;
  logic        conflict_hit;

  // Count cycles where a waiting fetch loses to a data access that either
  // owns the port now or is being granted this cycle; saturates at all-ones.
  always_comb begin
    conflict_hit = if_req & ~if_ready_q &
                   (((state_q == ACCESS) & owner_data_q) | (grant & grant_data));
    conflict_d   = conflict_q;
    if (conflict_hit && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'd0;
`endif

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  // write enable only qualifies the access window, never an idle bus
  assign mem_we    = we_q & (state_q == ACCESS);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = (d_read | d_write) & ~d_ready_q;

endmodule
